mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the 16-to-1 multiplexer between 16 requesters.
- Drives the mux select S[3:0] and active-low enable E_N.
- Break-before-make: the select only changes while the mux is disabled.
- Sits directly in front of the 16:1 mux datapath; each requester's data feeds the mux input D[k].

---
 rtl/mux_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer that shares one 16:1 mux between
//   16 requesters. It drives the mux select and an active-low enable with
//   break-before-make timing: the select only moves while the mux is off.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to limit every grant to
//   MAX_HOLD cycles. When a grant is forcibly ended, a one-cycle pulse
//   appears on timeout_o. With the macro undefined, a grant lasts until
//   the requester drops its request, and timeout_o stays 0.
//
//   Ports
//     clk_i      rising-edge clock
//     rst_n_i    asynchronous active-low reset
//     req_i      per-requester level request, held until done
//     gnt_o      one-hot grant (registered)
//     s_o        mux select (registered)
//     e_n_o      mux enable, active-low (registered)
//     busy_o     high whenever the sequencer is not idle (registered)
//     timeout_o  one-cycle pulse when a grant is forcibly ended
//
//   state  | meaning
//   IDLE   | mux disabled, arbitrate among pending requests
//   SETUP  | select driven to winner, mux still disabled (settle cycle)
//   GRANT  | mux enabled for the winner until release or hold limit

module mux_rr_arbiter #(
  parameter int N_REQ    = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0] s_o,
  output logic             e_n_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             e_n_q, e_n_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [SEL_W-1:0] pick;
  logic             pick_vld;
  logic             req_k;
  logic             hold_expire;

  // s_q holds the current candidate/owner from SETUP onwards.
  assign req_k = req_i[s_q];

`ifdef MUX_ARB_TIMEOUT_EN
  // A release on the same edge as the limit still counts as a timeout,
  // so the limit does not look at req_k.
  assign hold_expire = (state_q == ST_GRANT) && (cnt_q == 8'(MAX_HOLD - 1));
`else
  assign hold_expire = 1'b0;
`endif

  // Round-robin search from ptr+1 upward. The loop runs from the largest
  // offset down so that the nearest set bit is the one assigned last.
  // Offset N_REQ wraps to ptr itself, which is how a sole requester gets
  // re-granted.
  always_comb begin
    logic [SEL_W-1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ptr_q + SEL_W'(i);
      if (req_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = req_k ? ST_GRANT : ST_IDLE;
      end
      ST_GRANT: begin
        if (hold_expire || !req_k) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. All outputs are registered, so this computes their
  // next values.
  always_comb begin
    s_d       = s_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    e_n_d     = e_n_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) s_d = pick;
      end
      ST_SETUP: begin
        // If the requester withdrew, nothing changes and ptr keeps its
        // old value.
        if (req_k) begin
          gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << s_q;
          e_n_d = 1'b0;
          ptr_d = s_q;
          cnt_d = 8'd0;
        end
      end
      ST_GRANT: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (hold_expire) begin
          gnt_d     = '0;
          e_n_d     = 1'b1;
          timeout_d = 1'b1;
        end else if (!req_k) begin
          gnt_d = '0;
          e_n_d = 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
        e_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q       <= '0;
      ptr_q     <= SEL_W'(N_REQ - 1);
      gnt_q     <= '0;
      e_n_q     <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      e_n_q     <= e_n_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign s_o       = s_q;
  assign e_n_o     = e_n_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int HOLD = 4;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [15:0] req_i   = '0;
  logic [15:0] gnt_o;
  logic [3:0]  s_o;
  logic        e_n_o;
  logic        busy_o;
  logic        timeout_o;

  mux_rr_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(HOLD)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .s_o       (s_o),
    .e_n_o     (e_n_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, who is waiting in the settle
  // cycle, who was served last, and how long the owner has held it.
  int         m_owner = -1;
  int         m_cand  = -1;
  int         m_last  = 15;
  int         m_held  = 0;
  logic [3:0] m_sel   = 4'd0;
  bit         m_to    = 0;
  bit         m_exp   = 0;

  logic [15:0] req_smp = '0;
  logic        rst_smp = 1'b0;

  function automatic int rr_pick(input logic [15:0] r, input int last);
    for (int d = 1; d <= 16; d++) begin
      if (r[(last + d) % 16]) return (last + d) % 16;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk_i);
    req_smp = req_i;
    rst_smp = rst_n_i;
  end

  // Single compare process: advance the model by the edge just passed,
  // then compare every output and the structural invariants.
  logic       prev_e_n = 1'b1;
  logic [3:0] prev_s   = 4'd0;

  initial forever begin
    @(negedge clk_i);
    if (!rst_n_i || !rst_smp) begin
      m_owner = -1; m_cand = -1; m_last = 15; m_held = 0; m_sel = 4'd0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        m_held++;
        m_exp = 0;
`ifdef MUX_ARB_TIMEOUT_EN
        m_exp = (m_held >= HOLD);
`endif
        if (m_exp) begin
          m_owner = -1;
          m_to    = 1;
        end else if (!req_smp[m_owner]) begin
          m_owner = -1;
        end
      end else if (m_cand >= 0) begin
        if (req_smp[m_cand]) begin
          m_owner = m_cand;
          m_last  = m_cand;
          m_held  = 0;
        end
        m_cand = -1;
      end else begin
        int k;
        k = rr_pick(req_smp, m_last);
        if (k >= 0) begin
          m_cand = k;
          m_sel  = 4'(k);
        end
      end
    end
    if (cmp_en) begin
      chk("m_gnt", 32'(gnt_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("m_sel", 32'(s_o), 32'(m_sel));
      chk("m_en_n", 32'(e_n_o), (m_owner >= 0) ? 32'd0 : 32'd1);
      chk("m_busy", 32'(busy_o), (m_owner >= 0 || m_cand >= 0) ? 32'd1 : 32'd0);
      chk("m_timeout", 32'(timeout_o), 32'(m_to));
      chk("inv_onehot0", 32'($onehot0(gnt_o)), 32'd1);
      chk("inv_en_gnt", 32'(e_n_o), (gnt_o == 16'd0) ? 32'd1 : 32'd0);
      if (!e_n_o) chk("inv_gnt_sel", 32'(gnt_o[s_o]), 32'd1);
      if (!e_n_o && !prev_e_n) chk("inv_sel_stable", 32'(s_o), 32'(prev_s));
    end
    prev_e_n = e_n_o;
    prev_s   = s_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_gnt(input int budget, output logic [15:0] g);
    for (int i = 0; i < budget && gnt_o == 16'd0; i++) @(negedge clk_i);
    g = gnt_o;
    if (g == 16'd0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_gnt: no grant within %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    req_i   = '0;
    tick(2);
    rst_n_i = 1'b1;
    tick(1);
  endtask

  logic [15:0] gv;

  initial begin
    // Reset values
    tick(3);
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_sel", 32'(s_o), 32'h0);
    chk("rst_en_n", 32'(e_n_o), 32'h1);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    rst_n_i = 1'b1;
    cmp_en  = 1;
    tick(1);

    // Single request, latency and release
    req_i = 16'h0020;
    tick(1);
    chk("single_setup_sel", 32'(s_o), 32'd5);
    chk("single_setup_en_n", 32'(e_n_o), 32'd1);
    chk("single_setup_gnt", 32'(gnt_o), 32'h0);
    tick(1);
    chk("single_gnt", 32'(gnt_o), 32'h0020);
    chk("single_en_n", 32'(e_n_o), 32'd0);
    tick(3);
    req_i = 16'h0000;
    tick(1);
    chk("single_rel_gnt", 32'(gnt_o), 32'h0);
    chk("single_rel_en_n", 32'(e_n_o), 32'd1);
    chk("single_rel_sel", 32'(s_o), 32'd5);
    tick(2);

    // Wrap-around after serving 15
    req_i = 16'h8000;
    wait_gnt(10, gv);
    chk("wrap_gnt15", 32'(gv), 32'h8000);
    req_i = 16'h0000;
    tick(1);
    req_i = 16'h0003;
    wait_gnt(10, gv);
    chk("wrap_gnt0", 32'(gv), 32'h0001);
    chk("wrap_sel0", 32'(s_o), 32'd0);
    req_i = 16'h0002;
    tick(1);
    req_i = 16'h0003;
    wait_gnt(10, gv);
    chk("wrap_next1", 32'(gv), 32'h0002);
    req_i = 16'h0000;
    tick(3);

    // Withdrawal during the settle cycle
    req_i = 16'h0008;
    tick(1);
    chk("abort_setup_sel", 32'(s_o), 32'd3);
    chk("abort_setup_busy", 32'(busy_o), 32'd1);
    req_i = 16'h0000;
    tick(1);
    chk("abort_gnt", 32'(gnt_o), 32'h0);
    chk("abort_en_n", 32'(e_n_o), 32'd1);
    chk("abort_sel", 32'(s_o), 32'd3);
    chk("abort_busy", 32'(busy_o), 32'd0);
    tick(1);
    chk("abort_gnt_late", 32'(gnt_o), 32'h0);
    req_i = 16'h0008;
    tick(2);
    chk("abort_regrant", 32'(gnt_o), 32'h0008);
    req_i = 16'h0000;
    tick(3);

    // Asynchronous reset in the middle of a grant
    req_i = 16'h0010;
    tick(2);
    chk("midrst_pre_gnt", 32'(gnt_o), 32'h0010);
    chk("midrst_pre_en_n", 32'(e_n_o), 32'd0);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt_o), 32'h0);
    chk("midrst_sel", 32'(s_o), 32'h0);
    chk("midrst_en_n", 32'(e_n_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    tick(2);
    req_i   = 16'h0000;
    rst_n_i = 1'b1;
    tick(2);

`ifdef MUX_ARB_TIMEOUT_EN
    // Two persistent requesters alternate under the hold limit
    begin
      logic [15:0] order [4];
      int lowc;
      int gap;
      order[0] = 16'h0001; order[1] = 16'h8000;
      order[2] = 16'h0001; order[3] = 16'h8000;
      do_reset();
      req_i = 16'h8001;
      for (int g = 0; g < 4; g++) begin
        wait_gnt(20, gv);
        chk("to_order", 32'(gv), 32'(order[g]));
        lowc = 0;
        while (!e_n_o && lowc < 50) begin
          lowc++;
          @(negedge clk_i);
        end
        chk("to_hold_len", 32'(lowc), 32'(HOLD));
        chk("to_pulse", 32'(timeout_o), 32'd1);
        if (g < 3) begin
          gap = 0;
          while (e_n_o && gap < 50) begin
            gap++;
            @(negedge clk_i);
          end
          chk("to_gap", 32'(gap), 32'd2);
        end
      end
      req_i = 16'h0000;
      tick(4);
    end
`else
    // Long hold without a limit; a second requester must wait
    req_i = 16'h0004;
    tick(2);
    chk("hold_gnt", 32'(gnt_o), 32'h0004);
    req_i = 16'h0084;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (c % 10 == 0) begin
        chk("hold_keep", 32'(gnt_o), 32'h0004);
        chk("hold_no_to", 32'(timeout_o), 32'd0);
      end
    end
    req_i = 16'h0080;
    tick(1);
    chk("hold_rel", 32'(gnt_o), 32'h0);
    tick(2);
    chk("hold_next7", 32'(gnt_o), 32'h0080);
    req_i = 16'h0000;
    tick(3);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] r;
      r = req_i;
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 99) == 0) r = '0;
      req_i = r;
      tick(1);
    end
    req_i = 16'h0000;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
